// File: rtl/flex_pkg.sv
// Shared types, defaults and helpers for the flex serial-to-parallel family.
package flex_pkg;

  localparam logic DEFAULT_RST_VAL = 1'b1;

  typedef enum logic {
    ORDER_LSB_FIRST = 1'b0,
    ORDER_MSB_FIRST = 1'b1
  } shift_order_e;

  // Counter width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/flex_bit_counter.sv
// Up-counter wrapping at a parameterised value; flags the wrapping increment.
module flex_bit_counter
  import flex_pkg::*;
#(
  parameter int unsigned CNT_W        = 3,
  parameter int unsigned ROLLOVER_VAL = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  output logic [CNT_W-1:0] count,
  output logic             rollover_flag
);

  localparam logic [CNT_W-1:0] Rollover = CNT_W'(ROLLOVER_VAL);

  logic [CNT_W-1:0] count_q, count_d;

  assign rollover_flag = count_enable && (count_q == Rollover);
  assign count         = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      count_d = rollover_flag ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/flex_stp_word.sv
// Serial-to-parallel word assembler with a valid/ready holding register and
// sticky overrun flag. All outputs are registered.
module flex_stp_word
  import flex_pkg::*;
#(
  parameter int unsigned NUM_BITS = 8,
  parameter logic        RST_VAL  = DEFAULT_RST_VAL,
  localparam int unsigned CNT_W   = clog2_min1(NUM_BITS)
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic                shift_enable,
  input  logic                serial_in,
  input  logic                msb_first,
  input  logic                word_ready,
  output logic [NUM_BITS-1:0] shift_out,
  output logic [CNT_W-1:0]    bit_count,
  output logic [NUM_BITS-1:0] word_out,
  output logic                word_valid,
  output logic                overrun
);

  localparam logic [NUM_BITS-1:0] FillVal = {NUM_BITS{RST_VAL}};

  shift_order_e        order;
  logic [NUM_BITS-1:0] shift_q, shift_d, shift_next;
  logic [NUM_BITS-1:0] word_q, word_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;
  logic                word_done;

  assign order = shift_order_e'(msb_first);

  always_comb begin
    shift_next = shift_q;
    unique case (order)
      ORDER_MSB_FIRST: shift_next = {shift_q[NUM_BITS-2:0], serial_in};
      ORDER_LSB_FIRST: shift_next = {serial_in, shift_q[NUM_BITS-1:1]};
      default:         shift_next = shift_q;
    endcase
  end

  flex_bit_counter #(
    .CNT_W       (CNT_W),
    .ROLLOVER_VAL(NUM_BITS - 1)
  ) u_bit_counter (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .count_enable (shift_enable),
    .count        (bit_count),
    .rollover_flag(word_done)
  );

  // A completion wins over a same-cycle consume: the new word stays valid.
  always_comb begin
    shift_d   = shift_q;
    word_d    = word_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (clear) begin
      shift_d   = FillVal;
      word_d    = FillVal;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      if (shift_enable) begin
        shift_d = shift_next;
      end
      if (word_done) begin
        word_d  = shift_next;
        valid_d = 1'b1;
        if (valid_q && !word_ready) begin
          overrun_d = 1'b1;
        end
      end else if (valid_q && word_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_q   <= FillVal;
      word_q    <= FillVal;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign shift_out  = shift_q;
  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign overrun    = overrun_q;

endmodule
